// File: rtl/rv32i_pkg.sv
// Shared RV32I front-end types and constants.
// Consumed by the fetch unit and its next-PC selector.
// Holds no logic of its own.
package rv32i_pkg;
   localparam int          XLEN             = 32;
   localparam logic [31:0] INSTR_NOP        = 32'h0000_0013;
   localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

   typedef enum logic [1:0] {
      FETCH   = 2'd0,
      VALID   = 2'd1,
      DISCARD = 2'd2
   } ifu_state_t;

   function automatic logic is_misaligned(input logic [1:0] lsb);
      return |lsb;
   endfunction
endpackage

// File: rtl/ifu_next_pc.sv
// Next-PC select: flush_pc over pc_target over pc+4. Redirect targets are word-aligned here.
// Latency: purely combinational.
// Backpressure: none; the caller decides when next_pc is loaded.
module ifu_next_pc #(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] flush_pc,
   input  logic [XLEN-1:0] pc_target,
   input  logic            take_flush,
   input  logic            take_branch,
   output logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] next_pc,
   output logic            misalign
);
   import rv32i_pkg::*;

   logic [XLEN-1:0] raw_target;
   logic            redirect;

   always_comb begin
      pc_plus4   = pc + XLEN'(4);
      redirect   = take_flush | take_branch;
      raw_target = take_flush ? flush_pc : pc_target;
      // The low bits are dropped silently; the error pulse reports them.
      next_pc    = redirect ? {raw_target[XLEN-1:2], 2'b00} : pc_plus4;
      misalign   = redirect & is_misaligned(raw_target[1:0]);
   end
endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch: owns the PC, single-outstanding imem req/ack, valid/ready to decode; FETCH_PERF_CNT_EN adds fetch_count.
// Latency: ack at edge N gives instr_valid after edge N; best case one instruction every 2 cycles.
// Backpressure: instr_ready=0 holds instr/pc/instr_valid and issues no imem request.
module instr_fetch_unit #(
   parameter int              XLEN     = rv32i_pkg::XLEN,
   parameter logic [XLEN-1:0] RESET_PC = XLEN'(rv32i_pkg::RESET_PC_DEFAULT)
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     instr,
   output logic            instr_valid,
   input  logic            instr_ready,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   input  logic            pc_src,
   input  logic [XLEN-1:0] pc_target,
   input  logic            flush,
   input  logic [XLEN-1:0] flush_pc,
`ifdef FETCH_PERF_CNT_EN
   output logic [31:0]     fetch_count,
`endif
   output logic            misalign_err
);
   import rv32i_pkg::*;

   ifu_state_t      state;
   logic [XLEN-1:0] stale_addr;
   logic [XLEN-1:0] next_pc;
   logic            ack;
   logic            consume;
   logic            misalign;

   assign ack       = imem_req & imem_ack;
   assign consume   = (state == VALID) & instr_ready;
   // While discarding, the pc already holds the flush target; the bus keeps the old address.
   assign imem_addr = (state == DISCARD) ? stale_addr : pc;

   ifu_next_pc #(.XLEN(XLEN)) u_next_pc (
      .pc          (pc),
      .flush_pc    (flush_pc),
      .pc_target   (pc_target),
      .take_flush  (flush),
      .take_branch (consume & pc_src),
      .pc_plus4    (pc_plus4),
      .next_pc     (next_pc),
      .misalign    (misalign)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state        <= FETCH;
         pc           <= RESET_PC;
         stale_addr   <= RESET_PC;
         instr        <= INSTR_NOP;
         instr_valid  <= 1'b0;
         imem_req     <= 1'b0;
         misalign_err <= 1'b0;
      end else begin
         misalign_err <= misalign;
         if (flush) begin
            pc          <= next_pc;
            instr_valid <= 1'b0;
            imem_req    <= 1'b1;
            case (state)
               FETCH: begin
                  // Only a request actually on the bus leaves a stale response behind.
                  if (imem_req && !imem_ack) begin
                     state      <= DISCARD;
                     stale_addr <= pc;
                  end else begin
                     state <= FETCH;
                  end
               end
               DISCARD: state <= ack ? FETCH : DISCARD;
               default: state <= FETCH;
            endcase
         end else begin
            case (state)
               FETCH: begin
                  imem_req <= 1'b1;
                  if (ack) begin
                     instr       <= imem_rdata;
                     instr_valid <= 1'b1;
                     imem_req    <= 1'b0;
                     state       <= VALID;
                  end
               end
               VALID: begin
                  if (instr_ready) begin
                     pc          <= next_pc;
                     instr_valid <= 1'b0;
                     imem_req    <= 1'b1;
                     state       <= FETCH;
                  end
               end
               DISCARD: begin
                  if (ack) state <= FETCH;
               end
               default: state <= FETCH;
            endcase
         end
      end
   end

`ifdef FETCH_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         fetch_count <= 32'd0;
      else if (instr_valid && instr_ready)
         fetch_count <= fetch_count + 32'd1;
   end
`endif
endmodule
